rsc_block_checker: RTL and testbench

- Receive side of the turbo link: accepts BLK_LEN 3-bit turbo symbols {parity2, parity1, systematic} over a valid/ready handshake.
- Recovers the data block from the systematic bits.
- Re-encodes the block through both constituent RSC encoders (encoder 2 via the block interleaver) and compares against the received parities.
- Emits the hard-decision data word, per-position parity mismatch masks and a mismatch count to downstream logic / the tt_um top-level output mux.

---
 rtl/turbo_pkg.sv | 32 +++
 rtl/rsc_enc_core.sv | 33 +++
 rtl/rsc_block_checker.sv | 152 +++++++++++++++
 tb/tb_rsc_block_checker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/turbo_pkg.sv
// Shared turbo-link definitions used by the encoder and the block checker.
//   SYM_SYS / SYM_P1 / SYM_P2 : bit positions of the fields inside a 3-bit symbol
//   chk_state_e               : block checker state machine encoding
//   rsc_step(s, u)            : one RSC step, returns {next_state[2:0], parity}
//   intlv_idx(k, mul, add, n) : block interleaver pi(k) = (mul*k + add) mod n
package turbo_pkg;

  localparam int SYM_SYS = 0;
  localparam int SYM_P1  = 1;
  localparam int SYM_P2  = 2;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ENC2    = 2'd1,
    ST_DONE    = 2'd2
  } chk_state_e;

  // State s[0]=D, s[1]=D^2, s[2]=D^3; feedback taps D^2,D^3, parity taps 1,D,D^3.
  function automatic logic [3:0] rsc_step(input logic [2:0] s, input logic u);
    logic a;
    a = u ^ s[1] ^ s[2];
    return {s[1], s[0], a, a ^ s[0] ^ s[2]};
  endfunction

  function automatic int unsigned intlv_idx(input int unsigned k,
                                            input int unsigned mul,
                                            input int unsigned add,
                                            input int unsigned n);
    return (mul * k + add) % n;
  endfunction

endpackage

// File: rtl/rsc_enc_core.sv
// One recursive systematic convolutional encoder: 3-bit state register with
// step enable and synchronous clear. Parity is combinational from the current
// state and the input bit so the caller can compare it in the same cycle.
//   clk, reset : clock, synchronous active-high reset
//   en         : advance the state by one step with input u
//   clr        : return the state to 0 (start of a new block)
//   u          : systematic input bit
//   parity     : parity bit produced by stepping with u from the current state
module rsc_enc_core
  import turbo_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic u,
  output logic parity
);

  logic [2:0] s;
  logic [3:0] step;

  assign step   = rsc_step(s, u);
  assign parity = step[0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clr) s <= 3'd0;
    else if (en)      s <= step[3:1];
  end

endmodule

// File: rtl/rsc_block_checker.sv
// Receive-side turbo block checker. Collects BLK_LEN symbols {p2, p1, u},
// checks parity1 on the fly through encoder 1, then re-encodes the block in
// interleaved order through encoder 2 to check parity2, and presents the
// decoded word, both mismatch masks and a running mismatch count.
//   clk, reset            : clock, synchronous active-high reset
//   in_sym/in_valid/in_ready : symbol input handshake
//   out_data              : decoded systematic bits, bit k = k-th symbol
//   out_p1_err/out_p2_err : per-position parity mismatch masks
//   out_err_cnt           : total mismatches (accumulated during the steps)
//   out_valid/out_ready   : result handshake
//   stat_blk_cnt/stat_bad_cnt : saturating block / bad-block counters, only
//                           present when BLOCK_STATS_EN is defined
module rsc_block_checker
  import turbo_pkg::*;
#(
  parameter int BLK_LEN   = 8,
  parameter int INTLV_MUL = 3,
  parameter int INTLV_ADD = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [2:0]                        in_sym,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [BLK_LEN-1:0]                out_data,
  output logic [BLK_LEN-1:0]                out_p1_err,
  output logic [BLK_LEN-1:0]                out_p2_err,
  output logic [$clog2(2*BLK_LEN+1)-1:0]    out_err_cnt,
  output logic                              out_valid,
`ifdef BLOCK_STATS_EN
  output logic [15:0]                       stat_blk_cnt,
  output logic [15:0]                       stat_bad_cnt,
`endif
  input  logic                              out_ready
);

  localparam int IDX_W = $clog2(BLK_LEN);
  localparam int CNT_W = $clog2(2*BLK_LEN+1);

  chk_state_e         state;
  logic [IDX_W-1:0]   k;
  // One extra bit: the step after the last interleaved step is the hand-off
  // cycle into DONE, giving the BLK_LEN+1 cycle result latency.
  logic [IDX_W:0]     j;
  logic [BLK_LEN-1:0] par2;

  logic               accept;
  logic               done_hs;
  logic               enc2_en;
  logic [IDX_W-1:0]   j_lo;
  logic [IDX_W-1:0]   pi_j;
  logic               p1;
  logic               p2;
  logic               m1;
  logic               m2;

  assign accept  = in_valid && in_ready;
  assign done_hs = out_valid && out_ready;
  assign enc2_en = (state == ST_ENC2) && !j[IDX_W];
  assign j_lo    = j[IDX_W-1:0];
  assign pi_j    = IDX_W'(intlv_idx(int'(j_lo), INTLV_MUL, INTLV_ADD, BLK_LEN));
  assign m1      = p1 ^ in_sym[SYM_P1];
  assign m2      = p2 ^ par2[j_lo];

  rsc_enc_core u_enc1 (
    .clk    (clk),
    .reset  (reset),
    .en     (accept),
    .clr    (done_hs),
    .u      (in_sym[SYM_SYS]),
    .parity (p1)
  );

  rsc_enc_core u_enc2 (
    .clk    (clk),
    .reset  (reset),
    .en     (enc2_en),
    .clr    (done_hs),
    .u      (out_data[pi_j]),
    .parity (p2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the symbol stores are small flop vectors, not RAM, so they are
      // reset along with the rest; a partial block never leaks into outputs.
      state       <= ST_COLLECT;
      k           <= '0;
      j           <= '0;
      par2        <= '0;
      out_data    <= '0;
      out_p1_err  <= '0;
      out_p2_err  <= '0;
      out_err_cnt <= '0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
`ifdef BLOCK_STATS_EN
      stat_blk_cnt <= '0;
      stat_bad_cnt <= '0;
`endif
    end else begin
      case (state)
        ST_COLLECT: begin
          if (in_valid) begin
            out_data[k]   <= in_sym[SYM_SYS];
            par2[k]       <= in_sym[SYM_P2];
            out_p1_err[k] <= m1;
            out_err_cnt   <= out_err_cnt + CNT_W'(m1);
            if (k == IDX_W'(BLK_LEN-1)) begin
              k        <= '0;
              state    <= ST_ENC2;
              in_ready <= 1'b0;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        ST_ENC2: begin
          if (!j[IDX_W]) begin
            out_p2_err[j_lo] <= m2;
            out_err_cnt      <= out_err_cnt + CNT_W'(m2);
            j                <= j + 1'b1;
          end else begin
            j         <= '0;
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
`ifdef BLOCK_STATS_EN
            if (stat_blk_cnt != 16'hFFFF) stat_blk_cnt <= stat_blk_cnt + 16'd1;
            if (out_err_cnt != '0 && stat_bad_cnt != 16'hFFFF)
              stat_bad_cnt <= stat_bad_cnt + 16'd1;
`endif
            out_valid   <= 1'b0;
            out_p1_err  <= '0;
            out_p2_err  <= '0;
            out_err_cnt <= '0;
            in_ready    <= 1'b1;
            state       <= ST_COLLECT;
          end
        end
        default: begin
          state    <= ST_COLLECT;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsc_block_checker.sv
// Self-checking bench for rsc_block_checker (BLK_LEN=8, pi(k)=(3k+1) mod 8).
// Reference model expresses the RSC as a recurrence over the feedback
// sequence a[n] and computes expected masks from received symbols.
module tb_rsc_block_checker;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] in_sym = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data, out_p1_err, out_p2_err;
  logic [4:0] out_err_cnt;
  logic       out_valid;
  logic       out_ready = 1'b0;
`ifdef BLOCK_STATS_EN
  logic [15:0] stat_blk_cnt, stat_bad_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rsc_block_checker dut (
    .clk         (clk),
    .reset       (reset),
    .in_sym      (in_sym),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_p1_err  (out_p1_err),
    .out_p2_err  (out_p2_err),
    .out_err_cnt (out_err_cnt),
    .out_valid   (out_valid),
`ifdef BLOCK_STATS_EN
    .stat_blk_cnt(stat_blk_cnt),
    .stat_bad_cnt(stat_bad_cnt),
`endif
    .out_ready   (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // p[n] = a[n]^a[n-1]^a[n-3], a[n] = u[n]^a[n-2]^a[n-3], a[<0]=0.
  function automatic logic [7:0] rsc_ref(input logic [7:0] u);
    int a [N+3];
    logic [7:0] p;
    foreach (a[i]) a[i] = 0;
    p = '0;
    for (int n = 0; n < N; n++) begin
      a[n+3] = int'(u[n]) ^ a[n+1] ^ a[n];
      p[n]   = 1'(a[n+3] ^ a[n+2] ^ a[n]);
    end
    return p;
  endfunction

  function automatic logic [7:0] interleave(input logic [7:0] u);
    logic [7:0] v;
    for (int j = 0; j < N; j++) v[j] = u[(3*j + 1) % N];
    return v;
  endfunction

  function automatic logic [23:0] make_block(input logic [7:0] d, input logic [7:0] f1,
                                             input logic [7:0] f2);
    logic [7:0] p1, p2;
    logic [23:0] b;
    p1 = rsc_ref(d) ^ f1;
    p2 = rsc_ref(interleave(d)) ^ f2;
    for (int k = 0; k < N; k++) b[3*k +: 3] = {p2[k], p1[k], d[k]};
    return b;
  endfunction

  // Expected {cnt, p2_err, p1_err, data} for an arbitrary received block.
  function automatic logic [28:0] expect_of(input logic [23:0] b);
    logic [7:0] d, r1, r2, e1, e2;
    for (int k = 0; k < N; k++) begin
      d[k]  = b[3*k];
      r1[k] = b[3*k+1];
      r2[k] = b[3*k+2];
    end
    e1 = rsc_ref(d) ^ r1;
    e2 = rsc_ref(interleave(d)) ^ r2;
    return {5'($countones(e1) + $countones(e2)), e2, e1, d};
  endfunction

  int exp_blk = 0;
  int exp_bad = 0;

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_blk = 0;
    exp_bad = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_outs_zero"}, {out_data, out_p1_err, out_p2_err, 3'b0, out_err_cnt}, 32'd0);
  endtask

  task automatic send_syms(input logic [23:0] b, input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      in_sym = b[3*k +: 3];
      in_valid = 1'b1;
      for (int w = 0; !in_ready; w++) begin
        if (w == 100) begin
          check("in_ready_timeout", 32'(in_ready), 32'd1);
          break;
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_result(output logic [28:0] r);
    r = {out_err_cnt, out_p2_err, out_p1_err, out_data};
    out_ready = 1'b1;
    exp_blk++;
    if (out_err_cnt != 0) exp_bad++;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_block(input string name, input logic [23:0] b, input bit gaps,
                           output logic [28:0] r);
    int lat;
    send_syms(b, N, gaps);
    wait_valid(lat);
    check({name, "_latency"}, 32'(lat), 32'(N + 1));
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    take_result(r);
    check({name, "_model"}, 32'(r), 32'(expect_of(b)));
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [7:0] f1;
    logic [7:0] f2;
    logic [7:0] exp_data;
    logic [7:0] exp_p1;
    logic [7:0] exp_p2;
    logic [4:0] exp_cnt;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [28:0] r;
    logic [28:0] held;
    logic [23:0] b;
    int lat;
    bit stable;

    vecs[0] = '{"all_zero",  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 5'd0};
    vecs[1] = '{"a5_clean",  8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 5'd0};
    vecs[2] = '{"a5_p1_s3",  8'hA5, 8'h08, 8'h00, 8'hA5, 8'h08, 8'h00, 5'd1};
    vecs[3] = '{"zero_p2",   8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h81, 5'd2};
    vecs[4] = '{"3c_mixed",  8'h3C, 8'hFF, 8'h10, 8'h3C, 8'hFF, 8'h10, 5'd9};

    do_reset();
    check_reset_state("reset");

    foreach (vecs[i]) begin
      run_block(vecs[i].name, make_block(vecs[i].data, vecs[i].f1, vecs[i].f2), 1'b0, r);
      check({vecs[i].name, "_table"}, 32'(r),
            32'({vecs[i].exp_cnt, vecs[i].exp_p2, vecs[i].exp_p1, vecs[i].exp_data}));
    end

    // DONE held with out_ready low while a symbol is offered.
    b = make_block(8'h5A, 8'h21, 8'h04);
    send_syms(b, N, 1'b0);
    wait_valid(lat);
    check("stall_latency", 32'(lat), 32'(N + 1));
    held = {out_err_cnt, out_p2_err, out_p1_err, out_data};
    stable = 1'b1;
    in_sym = 3'b111;
    in_valid = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if ({out_err_cnt, out_p2_err, out_p1_err, out_data} !== held || in_ready || !out_valid)
        stable = 1'b0;
    end
    check("stall_stable", 32'(stable), 32'd1);
    in_valid = 1'b0;
    take_result(r);
    check("stall_result", 32'(r), 32'(expect_of(b)));
    run_block("after_stall", make_block(8'hA5, 8'h00, 8'h00), 1'b0, r);
    check("after_stall_data", 32'(r[7:0]), 32'hA5);

    // Randomized blocks: half with consistent parities plus flips, half raw.
    for (int t = 0; t < 24; t++) begin
      if (t[0]) b = make_block(8'($urandom), 8'($urandom_range(0, 255) & 8'h11),
                               8'($urandom_range(0, 255) & 8'h42));
      else      b = 24'($urandom);
      run_block($sformatf("rand%0d", t), b, 1'b1, r);
    end

`ifdef BLOCK_STATS_EN
    check("stat_blk_pre", 32'(stat_blk_cnt), 32'(exp_blk));
    check("stat_bad_pre", 32'(stat_bad_cnt), 32'(exp_bad));
`endif

    // Reset mid-block discards the partial block.
    send_syms({8{3'b111}}, 5, 1'b0);
    do_reset();
    check_reset_state("mid_reset");
    run_block("post_reset", make_block(8'h00, 8'h00, 8'h00), 1'b0, r);
    check("post_reset_result", 32'(r), 32'd0);
`ifdef BLOCK_STATS_EN
    check("stat_blk_post", 32'(stat_blk_cnt), 32'd1);
    check("stat_bad_post", 32'(stat_bad_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
